// File: rtl/pll_reconfig_pkg.sv
// Shared types for the PLL reconfiguration sequencer: management register
// map, sequencer state encoding and profile word types.
package pll_reconfig_pkg;

    typedef enum logic [5:0] {
        ADDR_MODE   = 6'd0,
        ADDR_STATUS = 6'd1,
        ADDR_START  = 6'd2,
        ADDR_M      = 6'd4,
        ADDR_K      = 6'd7
    } mgmt_addr_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_MODE,
        ST_WR_M,
        ST_WR_K,
        ST_WR_START,
        ST_SETTLE,
        ST_WAIT_LOCK
    } seq_state_e;

    typedef logic [31:0] m_word_t;
    typedef logic [31:0] k_frac_t;

    localparam int TMO_W    = 20;
    localparam int SETTLE_W = 8;

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL locked flag into
// the management clock domain.
module pll_lock_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // shift the async level through two flops
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/pll_reconfig_seq.sv
// Sequencer for the altera_pll_reconfig management port: writes mode,
// M-counter, fractional K and START for the requested video profile
// (0 = NTSC, 1 = PAL), then waits for the PLL to re-lock.
//
// state        | meaning
// -------------+-----------------------------------------------------
// ST_IDLE      | waiting for profile_sel to differ from cur_profile
// ST_WR_MODE   | writing waitrequest mode (addr 0, data 0)
// ST_WR_M      | writing M-counter word for target profile
// ST_WR_K      | writing fractional K for target profile
// ST_WR_START  | writing START (addr 2, data 1)
// ST_SETTLE    | locked ignored while the PLL begins to relock
// ST_WAIT_LOCK | waiting for synchronized lock or the timeout
module pll_reconfig_seq
    import pll_reconfig_pkg::*;
#(
    parameter m_word_t M_WORD0      = 32'h0002_0504,
    parameter k_frac_t K_FRAC0      = 32'd702807747,
    parameter m_word_t M_WORD1      = 32'h0002_0504,
    parameter k_frac_t K_FRAC1      = 32'd429496730,
    parameter int      SETTLE_CYC   = 16,
    parameter int      LOCK_TIMEOUT = 1000000
) (
    input  logic        i_refclk,
    input  logic        i_rst_n,
    input  logic        i_profile_sel,
    input  logic        i_pll_locked,
    output logic [5:0]  o_mgmt_address,
    output logic        o_mgmt_write,
    output logic [31:0] o_mgmt_writedata,
    output logic        o_mgmt_read,
    input  logic        i_mgmt_waitrequest,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_lock_err,
    output logic        o_cur_profile
);

    // Timeout fires on the LOCK_TIMEOUT-th WAIT_LOCK cycle, so a dead PLL
    // reports done SETTLE_CYC + LOCK_TIMEOUT cycles after START is accepted.
    localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);

    seq_state_e          r_state;
    mgmt_addr_e          r_addr;
    logic                r_write;
    logic [31:0]         r_wdata;
    logic                r_busy;
    logic                r_done;
    logic                r_lock_err;
    logic                r_cur_profile;
    logic                r_tgt;
    logic [SETTLE_W-1:0] r_settle_cnt;
    logic [TMO_W-1:0]    r_tmo_cnt;
    logic                w_locked_sync;

    pll_lock_sync u_lock_sync (
        .i_clk   (i_refclk),
        .i_rst_n (i_rst_n),
        .i_async (i_pll_locked),
        .o_sync  (w_locked_sync)
    );

    // sequencer FSM with registered management-port and status outputs
    always_ff @(posedge i_refclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_addr        <= ADDR_MODE;
            r_write       <= 1'b0;
            r_wdata       <= 32'd0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_lock_err    <= 1'b0;
            r_cur_profile <= 1'b0;
            r_tgt         <= 1'b0;
            r_settle_cnt  <= '0;
            r_tmo_cnt     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_profile_sel != r_cur_profile) begin
                        r_tgt   <= i_profile_sel;
                        r_busy  <= 1'b1;
                        r_write <= 1'b1;
                        r_addr  <= ADDR_MODE;
                        r_wdata <= 32'd0;
                        r_state <= ST_WR_MODE;
                    end
                end
                ST_WR_MODE: begin
                    if (!i_mgmt_waitrequest) begin
                        r_addr  <= ADDR_M;
                        r_wdata <= r_tgt ? M_WORD1 : M_WORD0;
                        r_state <= ST_WR_M;
                    end
                end
                ST_WR_M: begin
                    if (!i_mgmt_waitrequest) begin
                        r_addr  <= ADDR_K;
                        r_wdata <= r_tgt ? K_FRAC1 : K_FRAC0;
                        r_state <= ST_WR_K;
                    end
                end
                ST_WR_K: begin
                    if (!i_mgmt_waitrequest) begin
                        r_addr  <= ADDR_START;
                        r_wdata <= 32'd1;
                        r_state <= ST_WR_START;
                    end
                end
                ST_WR_START: begin
                    if (!i_mgmt_waitrequest) begin
                        r_write      <= 1'b0;
                        r_addr       <= ADDR_MODE;
                        r_wdata      <= 32'd0;
                        r_settle_cnt <= SETTLE_LAST;
                        r_tmo_cnt    <= '0;
                        r_state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_settle_cnt == '0) begin
                        r_state <= ST_WAIT_LOCK;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (w_locked_sync || (r_tmo_cnt == TMO_LAST)) begin
                        r_cur_profile <= r_tgt;
                        r_lock_err    <= !w_locked_sync;
                        r_done        <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= ST_IDLE;
                    end else if (r_tmo_cnt != '1) begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_mgmt_address   = r_addr;
    assign o_mgmt_write     = r_write;
    assign o_mgmt_writedata = r_wdata;
    assign o_mgmt_read      = 1'b0;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_lock_err       = r_lock_err;
    assign o_cur_profile    = r_cur_profile;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed bench for pll_reconfig_seq with a shortened lock timeout.
module tb_pll_reconfig_seq;

    localparam logic [31:0] M0 = 32'h0002_0504;
    localparam logic [31:0] K0 = 32'd702807747;
    localparam logic [31:0] M1 = 32'h0002_0504;
    localparam logic [31:0] K1 = 32'd429496730;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        profile_sel;
    logic        pll_locked;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic        mgmt_read;
    logic        mgmt_waitrequest;
    logic        busy;
    logic        done;
    logic        lock_err;
    logic        cur_profile;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic stall_en = 1'b0;
    int   stall_cnt = 0;

    // monitor records
    int wr_a[$];
    int unsigned wr_d[$];
    int wr_c[$];
    int done_c[$];
    int wr_hi_cnt = 0;
    int stab_err  = 0;
    logic        prev_stall = 1'b0;
    logic [5:0]  prev_addr = '0;
    logic [31:0] prev_data = '0;

    pll_reconfig_seq #(.LOCK_TIMEOUT(1000)) dut (
        .i_refclk           (clk),
        .i_rst_n            (rst_n),
        .i_profile_sel      (profile_sel),
        .i_pll_locked       (pll_locked),
        .o_mgmt_address     (mgmt_address),
        .o_mgmt_write       (mgmt_write),
        .o_mgmt_writedata   (mgmt_writedata),
        .o_mgmt_read        (mgmt_read),
        .i_mgmt_waitrequest (mgmt_waitrequest),
        .o_busy             (busy),
        .o_done             (done),
        .o_lock_err         (lock_err),
        .o_cur_profile      (cur_profile)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // slave model: stall each write for 3 cycles when enabled
    always @(posedge clk) begin
        if (mgmt_write && mgmt_waitrequest) stall_cnt <= stall_cnt + 1;
        else                                stall_cnt <= 0;
    end
    assign mgmt_waitrequest = stall_en && mgmt_write && (stall_cnt < 3);

    always @(negedge clk) begin
        if (mgmt_write) begin
            wr_hi_cnt <= wr_hi_cnt + 1;
            if (prev_stall && (mgmt_address != prev_addr || mgmt_writedata != prev_data))
                stab_err <= stab_err + 1;
        end
        prev_stall <= mgmt_write && mgmt_waitrequest;
        prev_addr  <= mgmt_address;
        prev_data  <= mgmt_writedata;
        if (mgmt_write && !mgmt_waitrequest) begin
            wr_a.push_back(int'(mgmt_address));
            wr_d.push_back(mgmt_writedata);
            wr_c.push_back(cyc);
        end
        if (done) done_c.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < budget);
        check({tag, "_done_seen"}, 32'(done), 32'd1);
    endtask

    task automatic wait_wr_addr(input logic [5:0] a, input int budget, input string tag);
        int n = 0;
        do begin
            step(1);
            n++;
        end while (!(mgmt_write && mgmt_address == a) && n < budget);
        check({tag, "_addr_seen"}, 32'(mgmt_write && mgmt_address == a), 32'd1);
    endtask

    task automatic check_seq(input int b, input logic [31:0] m, input logic [31:0] k, input string tag);
        check({tag, "_nwr"}, 32'(wr_a.size() - b), 32'd4);
        if (wr_a.size() - b >= 4) begin
            check({tag, "_a0"}, 32'(wr_a[b]),   32'd0);
            check({tag, "_d0"}, wr_d[b],        32'd0);
            check({tag, "_a1"}, 32'(wr_a[b+1]), 32'd4);
            check({tag, "_d1"}, wr_d[b+1],      m);
            check({tag, "_a2"}, 32'(wr_a[b+2]), 32'd7);
            check({tag, "_d2"}, wr_d[b+2],      k);
            check({tag, "_a3"}, 32'(wr_a[b+3]), 32'd2);
            check({tag, "_d3"}, wr_d[b+3],      32'd1);
        end
    endtask

    initial begin
        int b, bd, bh, lock_cyc, diff;
        rst_n       = 1'b0;
        profile_sel = 1'b0;
        pll_locked  = 1'b1;

        // 1: reset values, then 100 quiet idle cycles
        #5;
        check("rst_write", 32'(mgmt_write), 32'd0);
        check("rst_addr", 32'(mgmt_address), 32'd0);
        check("rst_data", mgmt_writedata, 32'd0);
        check("rst_read", 32'(mgmt_read), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_lockerr", 32'(lock_err), 32'd0);
        check("rst_cur", 32'(cur_profile), 32'd0);
        step(3);
        rst_n = 1'b1;
        bh = wr_hi_cnt;
        step(100);
        check("idle_writes", 32'(wr_hi_cnt - bh), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_cur", 32'(cur_profile), 32'd0);

        // 2: switch to profile 1, lock returns 40 cycles later
        b  = wr_a.size();
        bd = done_c.size();
        profile_sel = 1'b1;
        pll_locked  = 1'b0;
        step(40);
        pll_locked = 1'b1;
        lock_cyc   = cyc;
        wait_done(100, "t2");
        step(10);
        check_seq(b, M1, K1, "t2");
        if (wr_a.size() - b >= 4)
            check("t2_consecutive", 32'(wr_c[b+3] - wr_c[b]), 32'd3);
        check("t2_ndone", 32'(done_c.size() - bd), 32'd1);
        if (done_c.size() > bd)
            check("t2_lock_lat", 32'(done_c[bd] - lock_cyc), 32'd3);
        check("t2_cur", 32'(cur_profile), 32'd1);
        check("t2_lockerr", 32'(lock_err), 32'd0);
        check("t2_busy", 32'(busy), 32'd0);
        check("t2_read", 32'(mgmt_read), 32'd0);

        // 3: slave stalls each write for 3 cycles, back to profile 0
        stall_en = 1'b1;
        b  = wr_a.size();
        bh = wr_hi_cnt;
        profile_sel = 1'b0;
        wait_done(200, "t3");
        check_seq(b, M0, K0, "t3");
        check("t3_write_cycles", 32'(wr_hi_cnt - bh), 32'd16);
        check("t3_stable", 32'(stab_err), 32'd0);
        check("t3_cur", 32'(cur_profile), 32'd0);
        stall_en = 1'b0;
        step(2);

        // 4: lock never returns
        b  = wr_a.size();
        bd = done_c.size();
        pll_locked  = 1'b0;
        profile_sel = 1'b1;
        wait_done(1200, "t4");
        if (done_c.size() > bd && wr_a.size() - b >= 4) begin
            diff = done_c[bd] - (wr_c[b+3] + 1);
            check("t4_tmo_window", 32'(diff >= 1014 && diff <= 1018), 32'd1);
        end
        @(negedge clk);
        check("t4_lockerr", 32'(lock_err), 32'd1);
        check("t4_cur", 32'(cur_profile), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);
        b = wr_a.size();
        step(50);
        check("t4_no_retry", 32'(wr_a.size() - b), 32'd0);

        // 5: request flips back during WR_K of a profile-1 sequence
        pll_locked  = 1'b1;
        profile_sel = 1'b0;
        wait_done(100, "t5_pre");
        check("t5_pre_lockerr", 32'(lock_err), 32'd0);
        step(2);
        b  = wr_a.size();
        bd = done_c.size();
        profile_sel = 1'b1;
        wait_wr_addr(6'd7, 20, "t5_wrk");
        profile_sel = 1'b0;
        wait_done(100, "t5_first");
        wait_done(100, "t5_second");
        step(2);
        check("t5_nwr", 32'(wr_a.size() - b), 32'd8);
        check("t5_ndone", 32'(done_c.size() - bd), 32'd2);
        if (wr_a.size() - b >= 8 && done_c.size() - bd >= 2) begin
            check("t5_k_first", wr_d[b+2], K1);
            check("t5_k_second", wr_d[b+6], K0);
            check("t5_restart_gap", 32'(wr_c[b+4] - done_c[bd]), 32'd1);
        end
        check("t5_cur", 32'(cur_profile), 32'd0);

        // 6: reset during WAIT_LOCK, then full restart
        pll_locked  = 1'b0;
        profile_sel = 1'b1;
        wait_wr_addr(6'd2, 20, "t6_start");
        step(30);
        check("t6_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_write", 32'(mgmt_write), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_cur", 32'(cur_profile), 32'd0);
        step(3);
        pll_locked = 1'b1;
        b = wr_a.size();
        rst_n = 1'b1;
        wait_done(100, "t6");
        check_seq(b, M1, K1, "t6");
        @(negedge clk);
        check("t6_cur", 32'(cur_profile), 32'd1);
        check("t6_lockerr", 32'(lock_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
